fifo_pop_stage: RTL and testbench

//   Downstream drain stage for the fifo block: issues fifo pops and captures fifo data_out one cycle later.

---
 rtl/fifo_pop_stage.sv | 107 ++++++++++
 tb/tb_fifo_pop_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stage.sv
// Drain stage for the fifo block: issues pops, captures data_out a cycle later and presents the
// captured entries as a valid/ready stream through a 2-entry ordered skid buffer.
module fifo_pop_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16,
  parameter bit          DEBUG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fifo_q_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e             occ_q, occ_d;
  logic             infl_q, infl_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       deq;
  logic [2:0] fill;
  logic [1:0] rem;

  assign out_valid = (occ_q != StEmpty);
  assign out_data  = slot0_q;
  assign out_count = cnt_q;
  assign deq       = out_valid && out_ready;

  // Occupancy after this edge if nothing new is popped; deq implies occ >= 1, so no underflow.
  assign fill = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, deq};
  assign rem  = occ_q - {1'b0, deq};

  assign fifo_pop = !fifo_q_empty && !flush && (fill < 3'd2);

  always_comb begin
    occ_d   = occ_q;
    infl_d  = fifo_pop;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;

    if (deq) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Captured entry goes behind whatever survives the dequeue.
    if (infl_q && !flush) begin
      if (rem == 2'd0) begin
        slot0_d = fifo_data;
      end else begin
        slot1_d = fifo_data;
      end
    end

    unique case (fill[1:0])
      2'd0:    occ_d = StEmpty;
      2'd1:    occ_d = StOne;
      default: occ_d = StTwo;
    endcase

    if (flush) begin
      occ_d  = StEmpty;
      infl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= StEmpty;
      infl_q  <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  if (DEBUG) begin : g_debug
    always_ff @(posedge clk) begin
      if (rst_n) begin
        if (flush) begin
          $display("fifo_pop_stage: flush occ=%0d infl=%0b", occ_q, infl_q);
        end else if (infl_q) begin
          $display("fifo_pop_stage: capture %0h", fifo_data);
        end
        if (deq) begin
          $display("fifo_pop_stage: deliver %0h count=%0d", out_data, cnt_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Directed bench for fifo_pop_stage with a small behavioural fifo feeding it.
module tb_fifo_pop_stage;

  localparam int unsigned W = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_q_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_pop;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo_q[$];

  fifo_pop_stage #(.WIDTH(W), .CNT_W(CW), .DEBUG(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_q_empty (fifo_q_empty),
    .fifo_data    (fifo_data),
    .fifo_pop     (fifo_pop),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  // Upstream fifo: data_out registered on the pop edge; flush drops its contents too.
  always @(posedge clk) begin
    if (flush) fifo_q.delete();
    else if (fifo_pop && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
  end

  always begin
    @(posedge clk);
    #2;
    fifo_q_empty = (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    fifo_q.push_back(v);
  endtask

  // Collects n deliveries in order, bounded so a stuck DUT still reaches the summary.
  task automatic drain(input int n, input logic [W-1:0] base, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 4 * n + 10) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check(tag, 32'(out_data), 32'(base + W'(got)));
        got++;
      end
      cyc++;
    end
    check({tag, "_n"}, 32'(got), 32'(n));
  endtask

  initial begin
    logic         exp_v[6];
    logic [W-1:0] exp_d[6];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{16'h0, 16'h0, 16'hA001, 16'hA002, 16'hA003, 16'h0};

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // 1: streaming with constant ready
    next_cycle();
    out_ready = 1'b1;
    push(16'hA001); push(16'hA002); push(16'hA003);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("t1_pop0", 32'(fifo_pop), 32'd1);
      check($sformatf("t1_valid%0d", i), 32'(out_valid), 32'(exp_v[i]));
      if (exp_v[i]) check($sformatf("t1_data%0d", i), 32'(out_data), 32'(exp_d[i]));
    end
    check("t1_count", 32'(out_count), 32'd3);

    // 2: backpressure stops popping at two held entries
    next_cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
    @(negedge clk); check("t2_pop0", 32'(fifo_pop), 32'd1);
    @(negedge clk); check("t2_pop1", 32'(fifo_pop), 32'd1);
    @(negedge clk); check("t2_pop2", 32'(fifo_pop), 32'd0);
    @(negedge clk); check("t2_pop3", 32'(fifo_pop), 32'd0);
    check("t2_hold_valid", 32'(out_valid), 32'd1);
    check("t2_hold_data", 32'(out_data), 32'hD000);
    check("t2_fifo_left", 32'(fifo_q.size()), 32'd3);
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t2_data%0d", i), 32'(out_data), 32'hD000 + 32'(i));
    end
    @(negedge clk);
    check("t2_idle", 32'(out_valid), 32'd0);
    check("t2_count", 32'(out_count), 32'd8);

    // 3: flush with one held and one in flight
    next_cycle();
    out_ready = 1'b0;
    push(16'hE000); push(16'hE001); push(16'hE002);
    next_cycle();
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("t3_pre_valid", 32'(out_valid), 32'd1);
    check("t3_flush_pop", 32'(fifo_pop), 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_count", 32'(out_count), 32'd8);
    @(negedge clk);
    check("t3_stale", 32'(out_valid), 32'd0);
    next_cycle();
    out_ready = 1'b1;
    push(16'hF000);
    drain(1, 16'hF000, "t3_after");
    @(negedge clk);
    check("t3_count2", 32'(out_count), 32'd9);

    // 4: flush coinciding with a dequeue
    next_cycle();
    push(16'h1111); push(16'h2222); push(16'h3333);
    next_cycle();
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_data", 32'(out_data), 32'h1111);
    check("t4_flush_pop", 32'(fifo_pop), 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("t4_count", 32'(out_count), 32'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // 5: asynchronous reset mid-stream
    next_cycle();
    for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i));
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("t5_pre_data", 32'(out_data), 32'h6000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_count", 32'(out_count), 32'd0);
    check("t5_rst_data", 32'(out_data), 32'd0);
    #1 rst_n = 1'b1;
    drain(1, 16'h6003, "t5_resume");
    @(negedge clk);
    check("t5_count", 32'(out_count), 32'd1);

    // 6: delivered-entry counter wraps at 2^CW
    next_cycle();
    for (int i = 0; i < 14; i++) push(16'h7000 + 16'(i));
    drain(14, 16'h7000, "t6_data");
    @(negedge clk);
    check("t6_count15", 32'(out_count), 32'd15);
    next_cycle();
    push(16'h7777);
    drain(1, 16'h7777, "t6_last");
    @(negedge clk);
    check("t6_wrap", 32'(out_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
